// File: rtl/clk_div_sched_if.sv
// Run-control and configuration bundle for clk_div_sched.
// Carries tick_cnt only when CLK_DIV_SCHED_TICK_CNT_EN is defined.
interface clk_div_sched_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             run;
    logic             step;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             div_clk;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] cur_div;
`ifdef CLK_DIV_SCHED_TICK_CNT_EN
    logic [15:0]      tick_cnt;
`endif

    modport master (
        output run, step, cfg_valid, cfg_div,
`ifdef CLK_DIV_SCHED_TICK_CNT_EN
        input  tick_cnt,
`endif
        input  cfg_ready, div_clk, tick, busy, cur_div
    );

    modport slave (
        input  run, step, cfg_valid, cfg_div,
`ifdef CLK_DIV_SCHED_TICK_CNT_EN
        output tick_cnt,
`endif
        output cfg_ready, div_clk, tick, busy, cur_div
    );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable divider with run/stop/step sequencing and boundary-safe divide reload.
// Optional tick counter output enabled by CLK_DIV_SCHED_TICK_CNT_EN.
module clk_div_sched #(
    parameter int unsigned      CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(32'd10_000_000)
) (
    input  logic            clk,
    input  logic            rst,
    clk_div_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0] cur_div_r, cur_div_nxt_s;
    logic [CNT_W-1:0] pend_r, pend_nxt_s;
    logic             ready_r, ready_nxt_s;
    logic             div_clk_r, div_clk_nxt_s;
    logic             tick_r;
    logic             busy_r;
    logic             term_s;
    logic             xfer_s;

    // Terminal count only counts while the divider is active.
    assign term_s = (state_r != ST_IDLE) && (cnt_r == cur_div_r);
    assign xfer_s = bus.cfg_valid && ready_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.run) begin
                    state_nxt_s = ST_RUN;
                end else if (bus.step) begin
                    state_nxt_s = ST_STEP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (term_s && !bus.run) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STEP: begin
                if (term_s) begin
                    state_nxt_s = bus.run ? ST_RUN : ST_IDLE;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Counter, output phase and divide-value scheduling.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        div_clk_nxt_s = div_clk_r;
        cur_div_nxt_s = cur_div_r;
        pend_nxt_s    = pend_r;
        ready_nxt_s   = ready_r;

        if (state_r == ST_IDLE) begin
            cnt_nxt_s = '0;
        end else if (term_s) begin
            cnt_nxt_s     = '0;
            div_clk_nxt_s = ~div_clk_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end

        // A new value never disturbs a half-period already in flight.
        if (xfer_s) begin
            if ((state_r == ST_IDLE) || term_s) begin
                cur_div_nxt_s = bus.cfg_div;
            end else begin
                pend_nxt_s  = bus.cfg_div;
                ready_nxt_s = 1'b0;
            end
        end else if (term_s && !ready_r) begin
            cur_div_nxt_s = pend_r;
            ready_nxt_s   = 1'b1;
        end else begin
            ready_nxt_s = ready_r;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            cur_div_r <= DEFAULT_DIV;
            pend_r    <= '0;
            ready_r   <= 1'b1;
            div_clk_r <= 1'b0;
            tick_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            cur_div_r <= cur_div_nxt_s;
            pend_r    <= pend_nxt_s;
            ready_r   <= ready_nxt_s;
            div_clk_r <= div_clk_nxt_s;
            tick_r    <= term_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.cfg_ready = ready_r;
    assign bus.div_clk   = div_clk_r;
    assign bus.tick      = tick_r;
    assign bus.busy      = busy_r;
    assign bus.cur_div   = cur_div_r;

`ifdef CLK_DIV_SCHED_TICK_CNT_EN
    logic [15:0] tick_cnt_r;

    // Tick counter; a config transfer clears it even on a tick edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= 16'd0;
        end else if (xfer_s) begin
            tick_cnt_r <= 16'd0;
        end else if (term_s) begin
            tick_cnt_r <= tick_cnt_r + 16'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    assign bus.tick_cnt = tick_cnt_r;
`endif
endmodule

// File: tb/tb_clk_div_sched.sv
// Directed-vector bench for clk_div_sched built with DEFAULT_DIV=3.
module tb_clk_div_sched;
    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    clk_div_sched_if #(.CNT_W(32)) bus ();

    clk_div_sched #(.CNT_W(32), .DEFAULT_DIV(32'd3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div = 32'd0;
        cyc(2);
        check_vec("rst_div_clk", bus.div_clk, 1'b0);
        check_vec("rst_tick", bus.tick, 1'b0);
        check_vec("rst_busy", bus.busy, 1'b0);
        check_vec("rst_cur_div", bus.cur_div, 32'd3);
        check_vec("rst_ready", bus.cfg_ready, 1'b1);

        // Free run with cur_div=3: tick every 4 cycles, div_clk period 8.
        rst = 1'b0;
        bus.run = 1'b1;
        cyc(1);
        check_vec("run_entry_busy", bus.busy, 1'b1);
        check_vec("run_entry_tick", bus.tick, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            check_vec("run_tick_a", bus.tick, (i == 4));
        end
        check_vec("run_div_clk_hi", bus.div_clk, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            check_vec("run_tick_b", bus.tick, (i == 4));
        end
        check_vec("run_div_clk_lo", bus.div_clk, 1'b0);

        // Reload to 0 at counter=1; current half-period finishes with 3.
        cyc(1);
        bus.cfg_valid = 1'b1;
        bus.cfg_div = 32'd0;
        cyc(1);
        bus.cfg_valid = 1'b0;
        check_vec("pend_ready_lo", bus.cfg_ready, 1'b0);
        cyc(1);
        check_vec("pend_tick_lo", bus.tick, 1'b0);
        check_vec("pend_cur_old", bus.cur_div, 32'd3);
        cyc(1);
        check_vec("pend_term_tick", bus.tick, 1'b1);
        check_vec("pend_cur_new", bus.cur_div, 32'd0);
        check_vec("pend_ready_hi", bus.cfg_ready, 1'b1);
        check_vec("pend_div_clk", bus.div_clk, 1'b1);
        cyc(1);
        check_vec("div0_tick1", bus.tick, 1'b1);
        check_vec("div0_clk1", bus.div_clk, 1'b0);
        cyc(1);
        check_vec("div0_tick2", bus.tick, 1'b1);
        check_vec("div0_clk2", bus.div_clk, 1'b1);
        bus.run = 1'b0;
        cyc(1);
        check_vec("stop_tick", bus.tick, 1'b1);
        check_vec("stop_busy", bus.busy, 1'b0);
        check_vec("stop_div_clk", bus.div_clk, 1'b0);
        cyc(1);
        check_vec("idle_tick", bus.tick, 1'b0);
        check_vec("idle_div_clk", bus.div_clk, 1'b0);

        // Single step with cur_div=2; a second step pulse inside STEP is ignored.
        bus.cfg_valid = 1'b1;
        bus.cfg_div = 32'd2;
        cyc(1);
        bus.cfg_valid = 1'b0;
        check_vec("idle_load_cur", bus.cur_div, 32'd2);
        check_vec("idle_load_ready", bus.cfg_ready, 1'b1);
        bus.step = 1'b1;
        cyc(1);
        check_vec("step_busy0", bus.busy, 1'b1);
        cyc(1);
        bus.step = 1'b0;
        check_vec("step_busy1", bus.busy, 1'b1);
        check_vec("step_tick1", bus.tick, 1'b0);
        cyc(1);
        check_vec("step_busy2", bus.busy, 1'b1);
        check_vec("step_tick2", bus.tick, 1'b0);
        cyc(1);
        check_vec("step_done_busy", bus.busy, 1'b0);
        check_vec("step_done_tick", bus.tick, 1'b1);
        check_vec("step_done_clk", bus.div_clk, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            check_vec("step_after_tick", bus.tick, 1'b0);
            check_vec("step_after_busy", bus.busy, 1'b0);
        end
        check_vec("step_after_clk", bus.div_clk, 1'b1);

        // cur_div=5, drop run at counter=2: period completes, then IDLE.
        bus.cfg_valid = 1'b1;
        bus.cfg_div = 32'd5;
        cyc(1);
        bus.cfg_valid = 1'b0;
        bus.run = 1'b1;
        cyc(1);
        check_vec("drop_entry_busy", bus.busy, 1'b1);
        cyc(2);
        bus.run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check_vec("drop_tick_lo", bus.tick, 1'b0);
            check_vec("drop_busy_hi", bus.busy, 1'b1);
        end
        cyc(1);
        check_vec("drop_term_tick", bus.tick, 1'b1);
        check_vec("drop_term_busy", bus.busy, 1'b0);
        check_vec("drop_term_clk", bus.div_clk, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check_vec("drop_idle_tick", bus.tick, 1'b0);
            check_vec("drop_idle_clk", bus.div_clk, 1'b0);
        end

        // cur_div=4, reset at counter=3 of the second half-period.
        bus.cfg_valid = 1'b1;
        bus.cfg_div = 32'd4;
        cyc(1);
        bus.cfg_valid = 1'b0;
        bus.run = 1'b1;
        cyc(1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            check_vec("rstmid_tick", bus.tick, (i == 5));
        end
        check_vec("rstmid_clk_hi", bus.div_clk, 1'b1);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus.run = 1'b0;
        check_vec("rstmid_div_clk", bus.div_clk, 1'b0);
        check_vec("rstmid_tick0", bus.tick, 1'b0);
        check_vec("rstmid_busy", bus.busy, 1'b0);
        check_vec("rstmid_cur_div", bus.cur_div, 32'd3);
        check_vec("rstmid_ready", bus.cfg_ready, 1'b1);
        cyc(1);
        check_vec("rstmid_no_tick", bus.tick, 1'b0);
        check_vec("rstmid_idle", bus.busy, 1'b0);

`ifdef CLK_DIV_SCHED_TICK_CNT_EN
        // tick_cnt wrap with cur_div=0, then cleared by a transfer on a tick edge.
        bus.cfg_valid = 1'b1;
        bus.cfg_div = 32'd0;
        cyc(1);
        bus.cfg_valid = 1'b0;
        check_vec("tcnt_clear_idle", bus.tick_cnt, 16'd0);
        bus.run = 1'b1;
        cyc(1);
        cyc(65536);
        check_vec("tcnt_wrap0", bus.tick_cnt, 16'd0);
        cyc(1);
        check_vec("tcnt_wrap1", bus.tick_cnt, 16'd1);
        bus.cfg_valid = 1'b1;
        bus.run = 1'b0;
        cyc(1);
        bus.cfg_valid = 1'b0;
        check_vec("tcnt_xfer_clear", bus.tick_cnt, 16'd0);
        check_vec("tcnt_xfer_tick", bus.tick, 1'b1);
        check_vec("tcnt_xfer_busy", bus.busy, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Run-control and configuration scheduler for the slow-clock datapath of the synth processor.
- Owns a programmable divide counter and produces the divided square wave `div_clk` plus a one-cycle `tick` strobe.
- Sequences run, stop and single-step commands.
- Accepts new divide values through a valid/ready port and applies them only at a half-period boundary, so `div_clk` never emits a runt phase.

Parameters:
- CNT_W, 32, width of the divide counter and divide value.
- DEFAULT_DIV, 10000000, active divide value loaded at reset. Half-period is DEFAULT_DIV+1 cycles.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level; 1 = free-run, 0 = stop at next boundary.
- step  input  1  single-cycle pulse; runs exactly one half-period when idle.
- cfg_valid  input  1  new divide value offered.
- cfg_div  input  CNT_W  divide value; half-period = cfg_div+1 cycles.
- cfg_ready  output  1  scheduler can accept cfg_div this cycle.
- div_clk  output  1  divided clock; toggles at each terminal count.
- tick  output  1  one-cycle pulse coincident with each div_clk toggle.
- busy  output  1  FSM not in IDLE.
- cur_div  output  CNT_W  currently active divide value.

Behaviour:
- Reset (rst=1 at a clk edge) puts the block in this state, overriding all other inputs that cycle:
  - div_clk=0, tick=0, busy=0.
  - counter=0, state=IDLE.
  - cur_div=DEFAULT_DIV, pending buffer empty, cfg_ready=1.
- Reset mid-period aborts the period immediately. No final toggle.
- FSM states:
  - IDLE: counter held at 0; div_clk holds its level.
    - run=1 -> RUN.
    - else step=1 -> STEP.
    - run and step together: run wins, step is dropped.
  - RUN: counter increments each cycle.
    - At terminal (counter==cur_div): counter<=0, div_clk<=~div_clk, tick=1 for that cycle.
    - At terminal with run=0 -> IDLE; otherwise stay in RUN.
    - run falling mid-period does not truncate the period.
  - STEP: counts like RUN. At terminal: toggle, tick, -> IDLE.
    - step pulses received while in STEP are ignored.
    - run=1 at the STEP terminal -> RUN.
- Latency:
  - First tick occurs cur_div+1 cycles after the cycle RUN/STEP is entered.
  - Entry happens on the edge after run/step is sampled.
- Divide arithmetic:
  - Counter is CNT_W bits, unsigned.
  - cur_div=0 gives a tick every cycle while running (div_clk = clk/2).
  - cur_div=2^CNT_W-1 is legal; no overflow, since the counter resets at terminal.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - Buffering is one-deep; cfg_ready = !pending_vld.
  - In IDLE, an accepted value loads cur_div directly on the next edge. The pending buffer is not used.
  - In RUN/STEP, an accepted value goes to pending. At the next terminal, cur_div<=pending and pending is cleared. cfg_ready returns 1 the cycle after the terminal.
  - Transfer in the same cycle as a terminal: the value loads cur_div at that terminal edge and governs the next half-period. pending stays empty.
  - The current half-period always completes with the old cur_div.
  - cfg_valid while cfg_ready=0: no transfer; the requester must hold the value.
- tick and div_clk are registered outputs. busy is registered and equals (state!=IDLE).

Optional Feature:
- Macro: CLK_DIV_SCHED_TICK_CNT_EN.
- Defined:
  - Adds output tick_cnt [15:0], reset to 0.
  - Increments on every tick and wraps from 16'hFFFF to 0.
  - A successful config transfer also clears tick_cnt, on the same edge it is accepted. If a tick occurs in that same cycle, the clear wins and tick_cnt becomes 0.
- Undefined: no tick_cnt port or logic. All other behaviour is identical.

Test Plan:
- Reset with DEFAULT_DIV overridden to 3, then run=1 held -> first tick 4 cycles after entering RUN. tick every 4 cycles; div_clk period 8 cycles; cur_div=3.
- RUN with cur_div=3; at counter=1 send cfg_div=0 -> cfg_ready drops the next cycle. Current half-period completes at 4 cycles. Ticks then occur every cycle. cfg_ready returns 1 after the terminal.
- IDLE, step pulse with cur_div=2 -> busy=1 for 3 cycles, exactly one tick, div_clk toggles once, back to IDLE. A second step during STEP produces no extra tick.
- RUN with cur_div=5; drop run at counter=2 -> 3 more cycles to terminal, one tick, then IDLE. div_clk holds its level with no further toggles.
- RUN with cur_div=4; assert rst at counter=3 -> next cycle div_clk=0, tick=0, busy=0, cur_div=DEFAULT_DIV. No tick is emitted.
- With CLK_DIV_SCHED_TICK_CNT_EN, cur_div=0, run 65537 cycles -> tick_cnt wraps to 1. A cfg transfer then forces tick_cnt=0.
